// File: rtl/pop_sequence_controller.sv
// Pump/dark/probe/gap sequencer for pump-optical-pumping runs.
// Each phase lasts a fixed number of ticks, and runs repeat REPEAT times (0 = forever).
module pop_sequence_controller #(
  parameter logic [15:0] PUMP_TICKS  = 16'd40,
  parameter logic [15:0] DARK_TICKS  = 16'd100,
  parameter logic [15:0] PROBE_TICKS = 16'd20,
  parameter logic [15:0] GAP_TICKS   = 16'd10,
  parameter logic [7:0]  REPEAT      = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  output logic [2:0] state,
  output logic       pump_gate,
  output logic       probe_gate,
  output logic       busy,
  output logic       done,
  output logic [7:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUMP  = 3'd1,
    DARK  = 3'd2,
    PROBE = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Terminal counter value per phase; a dwell of 0 behaves like a dwell of 1.
  localparam logic [15:0] PUMP_LAST  = (PUMP_TICKS  == 16'd0) ? 16'd0 : PUMP_TICKS  - 16'd1;
  localparam logic [15:0] DARK_LAST  = (DARK_TICKS  == 16'd0) ? 16'd0 : DARK_TICKS  - 16'd1;
  localparam logic [15:0] PROBE_LAST = (PROBE_TICKS == 16'd0) ? 16'd0 : PROBE_TICKS - 16'd1;
  localparam logic [15:0] GAP_LAST   = (GAP_TICKS   == 16'd0) ? 16'd0 : GAP_TICKS   - 16'd1;

  function automatic logic [15:0] last_count(input state_t s);
    case (s)
      PUMP:    return PUMP_LAST;
      DARK:    return DARK_LAST;
      PROBE:   return PROBE_LAST;
      GAP:     return GAP_LAST;
      default: return 16'd0;
    endcase
  endfunction

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [7:0]  r_cycle;
  logic        r_pump;
  logic        r_probe;
  logic        r_busy;
  logic        r_done;

  state_t      w_nxt_state;
  logic [15:0] w_nxt_cnt;
  logic [7:0]  w_nxt_cycle;
  logic        w_done;
  logic [7:0]  w_cyc_inc;
  logic        w_phase_end;

  assign w_cyc_inc   = r_cycle + 8'd1;
  assign w_phase_end = tick && (r_cnt == last_count(r_state));

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_cycle = r_cycle;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          w_nxt_state = PUMP;
          w_nxt_cnt   = 16'd0;
          w_nxt_cycle = 8'd0;
        end
      end
      PUMP, DARK, PROBE, GAP: begin
        // Abort wins over everything, including the final GAP exit.
        if (stop) begin
          w_nxt_state = IDLE;
          w_nxt_cnt   = 16'd0;
        end else if (w_phase_end) begin
          w_nxt_cnt = 16'd0;
          case (r_state)
            PUMP:  w_nxt_state = DARK;
            DARK:  w_nxt_state = PROBE;
            PROBE: w_nxt_state = GAP;
            default: begin
              w_nxt_cycle = w_cyc_inc;
              if ((REPEAT != 8'd0) && (w_cyc_inc == REPEAT)) begin
                w_nxt_state = IDLE;
                w_done      = 1'b1;
              end else begin
                w_nxt_state = PUMP;
              end
            end
          endcase
        end else if (tick) begin
          w_nxt_cnt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = 16'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge as state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
      r_cycle <= 8'd0;
      r_pump  <= 1'b0;
      r_probe <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_cycle <= w_nxt_cycle;
      r_pump  <= (w_nxt_state == PUMP);
      r_probe <= (w_nxt_state == PROBE);
      r_busy  <= (w_nxt_state != IDLE);
      r_done  <= w_done;
    end
  end

  assign state       = r_state;
  assign pump_gate   = r_pump;
  assign probe_gate  = r_probe;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cycle_count = r_cycle;

endmodule

// File: tb/tb_pop_sequence_controller.sv
// Directed bench for pop_sequence_controller: PUMP=3, DARK=2, PROBE=4, GAP=1, tick every 4th clk.
module tb_pop_sequence_controller;

  logic clk, reset, tick;
  logic start_a, stop_a, start_b, stop_b, start_c, stop_c;
  logic [2:0] a_state, b_state, c_state;
  logic a_pump, a_probe, a_busy, a_done;
  logic b_pump, b_probe, b_busy, b_done;
  logic c_pump, c_probe, c_busy, c_done;
  logic [7:0] a_cyc, b_cyc, c_cyc;

  int n_checks = 0;
  int n_fail   = 0;
  int b_done_seen = 0;
  int pump_t, probe_t, busy_t, done_t;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] cyc;
    logic       dn;
  } vec_t;
  vec_t tbl [20];

  pop_sequence_controller #(.PUMP_TICKS(16'd3), .DARK_TICKS(16'd2), .PROBE_TICKS(16'd4),
    .GAP_TICKS(16'd1), .REPEAT(8'd2)) u_a (
    .clk(clk), .reset(reset), .tick(tick), .start(start_a), .stop(stop_a),
    .state(a_state), .pump_gate(a_pump), .probe_gate(a_probe), .busy(a_busy),
    .done(a_done), .cycle_count(a_cyc));

  pop_sequence_controller #(.PUMP_TICKS(16'd3), .DARK_TICKS(16'd2), .PROBE_TICKS(16'd4),
    .GAP_TICKS(16'd1), .REPEAT(8'd0)) u_b (
    .clk(clk), .reset(reset), .tick(tick), .start(start_b), .stop(stop_b),
    .state(b_state), .pump_gate(b_pump), .probe_gate(b_probe), .busy(b_busy),
    .done(b_done), .cycle_count(b_cyc));

  pop_sequence_controller #(.PUMP_TICKS(16'd0), .DARK_TICKS(16'd0), .PROBE_TICKS(16'd0),
    .GAP_TICKS(16'd0), .REPEAT(8'd1)) u_c (
    .clk(clk), .reset(reset), .tick(tick), .start(start_c), .stop(stop_c),
    .state(c_state), .pump_gate(c_pump), .probe_gate(c_probe), .busy(c_busy),
    .done(c_done), .cycle_count(c_cyc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_a(input string tag, input logic [2:0] st, input logic [7:0] cyc, input logic dn);
    chk({tag, ".state"}, int'(a_state), int'(st));
    chk({tag, ".pump"},  int'(a_pump),  int'(st == 3'd1));
    chk({tag, ".probe"}, int'(a_probe), int'(st == 3'd3));
    chk({tag, ".busy"},  int'(a_busy),  int'(st != 3'd0));
    chk({tag, ".done"},  int'(a_done),  int'(dn));
    chk({tag, ".cycle"}, int'(a_cyc),   int'(cyc));
    chk({tag, ".excl"},  int'(a_pump & a_probe), 0);
  endtask

  task automatic do_clk(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
    if (b_done) b_done_seen++;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      do_clk(1'b0); do_clk(1'b0); do_clk(1'b0); do_clk(1'b1);
    end
  endtask

  task automatic run_table(input string tag);
    pump_t = 0; probe_t = 0; busy_t = 0; done_t = 0;
    start_a = 1'b1; do_clk(1'b0); start_a = 1'b0;
    chk_a({tag, ".start"}, 3'd1, 8'd0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (a_pump)  pump_t++;
      if (a_probe) probe_t++;
      if (a_busy)  busy_t++;
      tick_n(1);
      if (a_done) done_t++;
      chk_a($sformatf("%s.t%0d", tag, k + 1), tbl[k].st, tbl[k].cyc, tbl[k].dn);
    end
    do_clk(1'b0);
    chk_a({tag, ".after"}, 3'd0, 8'd2, 1'b0);
    chk({tag, ".pump_ticks"},  pump_t,  6);
    chk({tag, ".probe_ticks"}, probe_t, 8);
    chk({tag, ".busy_ticks"},  busy_t,  20);
    chk({tag, ".done_count"},  done_t,  1);
  endtask

  initial begin
    tbl = '{
      '{3'd1, 8'd0, 1'b0}, '{3'd1, 8'd0, 1'b0}, '{3'd2, 8'd0, 1'b0}, '{3'd2, 8'd0, 1'b0},
      '{3'd3, 8'd0, 1'b0}, '{3'd3, 8'd0, 1'b0}, '{3'd3, 8'd0, 1'b0}, '{3'd3, 8'd0, 1'b0},
      '{3'd4, 8'd0, 1'b0}, '{3'd1, 8'd1, 1'b0}, '{3'd1, 8'd1, 1'b0}, '{3'd1, 8'd1, 1'b0},
      '{3'd2, 8'd1, 1'b0}, '{3'd2, 8'd1, 1'b0}, '{3'd3, 8'd1, 1'b0}, '{3'd3, 8'd1, 1'b0},
      '{3'd3, 8'd1, 1'b0}, '{3'd3, 8'd1, 1'b0}, '{3'd4, 8'd1, 1'b0}, '{3'd0, 8'd2, 1'b1}
    };
    reset = 1'b1; tick = 1'b0;
    start_a = 1'b1; stop_a = 1'b0;
    start_b = 1'b0; stop_b = 1'b0;
    start_c = 1'b0; stop_c = 1'b0;

    // reset dominates a concurrent start
    do_clk(1'b0); do_clk(1'b1);
    chk_a("reset", 3'd0, 8'd0, 1'b0);
    chk("reset.b_state", int'(b_state), 0);
    chk("reset.b_busy",  int'(b_busy),  0);
    start_a = 1'b0; reset = 1'b0;
    do_clk(1'b0);
    chk_a("idle", 3'd0, 8'd0, 1'b0);

    // two-cycle run
    run_table("run1");

    // continuous mode
    b_done_seen = 0;
    start_b = 1'b1; do_clk(1'b0); start_b = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      tick_n(1);
      if (k == 10) chk("cont.t10.cycle", int'(b_cyc), 1);
      if (k == 30) begin
        chk("cont.t30.cycle", int'(b_cyc), 3);
        chk("cont.t30.state", int'(b_state), 1);
        chk("cont.t30.pump",  int'(b_pump), 1);
      end
    end
    chk("cont.t35.state", int'(b_state), 3);
    chk("cont.t35.probe", int'(b_probe), 1);
    chk("cont.done_seen", b_done_seen, 0);
    stop_b = 1'b1; do_clk(1'b0); stop_b = 1'b0;
    chk("cont.stop.state", int'(b_state), 0);
    chk("cont.stop.busy",  int'(b_busy), 0);
    chk("cont.stop.cycle", int'(b_cyc), 3);
    chk("cont.stop.done",  int'(b_done), 0);

    // stop during DARK of cycle 2, with tick high on the same clk
    start_a = 1'b1; do_clk(1'b0); start_a = 1'b0;
    tick_n(13);
    chk_a("dark2", 3'd2, 8'd1, 1'b0);
    do_clk(1'b0);
    stop_a = 1'b1; do_clk(1'b1); stop_a = 1'b0;
    chk_a("abort", 3'd0, 8'd1, 1'b0);
    tick_n(1);
    chk_a("abort.hold", 3'd0, 8'd1, 1'b0);

    // stop coinciding with the final GAP exit
    start_a = 1'b1; do_clk(1'b0); start_a = 1'b0;
    tick_n(19);
    chk_a("gap2", 3'd4, 8'd1, 1'b0);
    do_clk(1'b0); do_clk(1'b0); do_clk(1'b0);
    stop_a = 1'b1; do_clk(1'b1); stop_a = 1'b0;
    chk_a("gapstop", 3'd0, 8'd1, 1'b0);

    // start held through a run, then start+stop in IDLE
    start_a = 1'b1; do_clk(1'b0);
    chk_a("hold.start", 3'd1, 8'd0, 1'b0);
    tick_n(12);
    chk_a("hold.t12", 3'd1, 8'd1, 1'b0);
    start_a = 1'b0;
    tick_n(8);
    chk_a("hold.end", 3'd0, 8'd2, 1'b1);
    start_a = 1'b1; stop_a = 1'b1; do_clk(1'b0);
    start_a = 1'b0; stop_a = 1'b0;
    chk_a("startstop", 3'd0, 8'd2, 1'b0);
    tick_n(2);
    chk_a("startstop.stay", 3'd0, 8'd2, 1'b0);

    // reset during PROBE of cycle 2, then a normal run
    start_a = 1'b1; do_clk(1'b0); start_a = 1'b0;
    tick_n(15);
    chk_a("probe2", 3'd3, 8'd1, 1'b0);
    do_clk(1'b0);
    reset = 1'b1; do_clk(1'b1); reset = 1'b0;
    chk_a("rstmid", 3'd0, 8'd0, 1'b0);
    run_table("run2");

    // tick starvation inside PUMP
    start_a = 1'b1; do_clk(1'b0); start_a = 1'b0;
    tick_n(1);
    chk_a("frz.t1", 3'd1, 8'd0, 1'b0);
    repeat (50) do_clk(1'b0);
    chk_a("frz.50", 3'd1, 8'd0, 1'b0);
    tick_n(1);
    chk_a("frz.t2", 3'd1, 8'd0, 1'b0);
    tick_n(1);
    chk_a("frz.t3", 3'd2, 8'd0, 1'b0);
    stop_a = 1'b1; do_clk(1'b0); stop_a = 1'b0;
    chk_a("frz.stop", 3'd0, 8'd0, 1'b0);

    // zero dwells act as one tick each
    start_c = 1'b1; do_clk(1'b0); start_c = 1'b0;
    chk("zero.start.state", int'(c_state), 1);
    chk("zero.start.pump",  int'(c_pump), 1);
    tick_n(1);
    chk("zero.t1.state", int'(c_state), 2);
    tick_n(1);
    chk("zero.t2.state", int'(c_state), 3);
    chk("zero.t2.probe", int'(c_probe), 1);
    tick_n(1);
    chk("zero.t3.state", int'(c_state), 4);
    tick_n(1);
    chk("zero.t4.state", int'(c_state), 0);
    chk("zero.t4.done",  int'(c_done), 1);
    chk("zero.t4.busy",  int'(c_busy), 0);
    chk("zero.t4.cycle", int'(c_cyc), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
